// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM state encoding, queue depth and decoder field positions.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [1:0] QDEPTH = 2'd2;

  localparam int OP_LSB    = 26;
  localparam int OP_W      = 2;
  localparam int FUNCT_LSB = 20;
  localparam int FUNCT_W   = 6;
  localparam int RD_LSB    = 12;
  localparam int RD_W      = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {word, pc} with registered head, flush and occupancy count.
// Entry 0 is always the head; the head reads as zero while the queue is empty.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  qentry_t    data_i,
  output qentry_t    head_o,
  output logic       valid_o,
  output logic [1:0] count_o
);

  qentry_t [1:0] mem_q, mem_d;
  logic    [1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (count_q != QDEPTH) begin
            mem_d[count_q[0]] = data_i;
            count_d           = count_q + 2'd1;
          end
        end
        2'b01: begin
          if (count_q != 2'd0) begin
            mem_d[0] = mem_q[1];
            count_d  = count_q - 2'd1;
          end
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count and shifts in behind the head.
          if (count_q == QDEPTH) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = data_i;
          end else begin
            mem_d[0] = data_i;
          end
          count_d = (count_q == 2'd0) ? 2'd1 : count_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign head_o  = valid_o ? mem_q[0] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: req/ack memory interface, 2-entry instruction queue,
// branch/PC-write redirect handling and decoder field slicing.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  target_q, target_d;

  logic         pop, take, push, flush;
  logic [31:0]  target;
  logic [1:0]   q_count;
  qentry_t      q_head;
  qentry_t      q_in;

  assign pop    = instr_valid & instr_ready;
  assign take   = pop & redirect;
  assign target = redirect_pc & ~32'h0000_0003;
  assign q_in   = '{word: imem_rdata, pc: fetch_pc_q};

  // A take always wins over a returning word: the word belongs to the wrong path.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    push       = 1'b0;
    flush      = 1'b0;
    imem_req   = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && !take) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          if ((q_count + 2'd1 - {1'b0, pop}) == QDEPTH) begin
            state_d = WAIT;
          end
        end else if (imem_ack && take) begin
          flush      = 1'b1;
          fetch_pc_d = target;
        end else if (take) begin
          flush    = 1'b1;
          target_d = target;
          state_d  = FLUSH;
        end
      end
      WAIT: begin
        if (take) begin
          flush      = 1'b1;
          fetch_pc_d = target;
          state_d    = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        // The stale request must complete before the target can be issued.
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_pc_d = target_q;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (q_in),
    .head_o  (q_head),
    .valid_o (instr_valid),
    .count_o (q_count)
  );

  assign imem_addr = fetch_pc_q;
  assign instr     = q_head.word;
  assign instr_pc  = q_head.pc;
  assign pc_plus8  = q_head.pc + 32'd8;
  assign op        = q_head.word[OP_LSB +: OP_W];
  assign funct     = q_head.word[FUNCT_LSB +: FUNCT_W];
  assign rd        = q_head.word[RD_LSB +: RD_W];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table plus hand-written
// sequences for delayed-ack redirect, field slicing, PC wrap and mid-request reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  int assertCount = 0;
  int failCount   = 0;

  int          ackDelay   = 0;
  int          waitCnt;
  bit          useFixed   = 1'b0;
  logic [31:0] fixedWord  = 32'hE3A0_1005;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc_plus8    (pc_plus8),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  // Memory model: acks after ackDelay wait cycles, returns data = address; drops on reset.
  assign imem_ack   = imem_req && (waitCnt == ackDelay);
  assign imem_rdata = imem_ack ? (useFixed ? fixedWord : imem_addr) : 32'hBAD0_BAD0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    waitCnt <= 0;
    else if (!imem_req || imem_ack) waitCnt <= 0;
    else                           waitCnt <= waitCnt + 1;
  end

  typedef struct {
    bit          doReset;
    logic        ready;
    logic        redir;
    logic [31:0] redirPc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
    logic [31:0] expInstr;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Holds reset for two edges, checks reset outputs, releases; returns at cycle 1 sample point.
  task automatic applyStimulus(input logic ready);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    instr_ready = ready;
    step();
    step();
    checkOutput("rst_req",   {31'b0, imem_req},    32'd0);
    checkOutput("rst_addr",  imem_addr,            32'd0);
    checkOutput("rst_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_pcp8",  pc_plus8,             32'd8);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;

    vecs[0]  = '{1, 1, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0};
    vecs[1]  = '{0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h0};
    vecs[2]  = '{0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   32'h4};
    vecs[3]  = '{0, 1, 0, 32'h0,   1, 32'hC,   1, 32'h8,   32'h8};
    vecs[4]  = '{1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0};
    vecs[5]  = '{0, 0, 0, 32'h0,   1, 32'h4,   1, 32'h0,   32'h0};
    vecs[6]  = '{0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0,   32'h0};
    vecs[7]  = '{0, 0, 0, 32'h0,   0, 32'h8,   1, 32'h0,   32'h0};
    vecs[8]  = '{0, 1, 0, 32'h0,   0, 32'h8,   1, 32'h0,   32'h0};
    vecs[9]  = '{0, 1, 1, 32'h103, 1, 32'h8,   1, 32'h4,   32'h4};
    vecs[10] = '{0, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0};
    vecs[11] = '{0, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, 32'h100};

    ackDelay = 0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].doReset) applyStimulus(vecs[i].ready);
      instr_ready = vecs[i].ready;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].redirPc;
      checkOutput($sformatf("v%0d_req", i),   {31'b0, imem_req},    {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d_addr", i),  imem_addr,            vecs[i].expAddr);
      checkOutput($sformatf("v%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("v%0d_pc", i),    instr_pc,             vecs[i].expPc);
      checkOutput($sformatf("v%0d_instr", i), instr,                vecs[i].expInstr);
      checkOutput($sformatf("v%0d_pcp8", i),  pc_plus8,             vecs[i].expPc + 32'd8);
      step();
    end
    redirect = 1'b0;

    // Redirect while the fetch of 8 is outstanding on a 3-wait memory.
    ackDelay = 3;
    applyStimulus(1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (instr_valid && instr_pc == 32'h4) found = 1'b1;
      else step();
    end
    checkOutput("dly_found", {31'b0, found}, 32'd1);
    checkOutput("dly_addr8", imem_addr, 32'h8);
    checkOutput("dly_noack", {31'b0, imem_ack}, 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("flush%0d_req", i),   {31'b0, imem_req},    32'd1);
      checkOutput($sformatf("flush%0d_addr", i),  imem_addr,            32'h8);
      checkOutput($sformatf("flush%0d_valid", i), {31'b0, instr_valid}, 32'd0);
      step();
    end
    checkOutput("tgt_req",   {31'b0, imem_req},    32'd1);
    checkOutput("tgt_addr",  imem_addr,            32'h100);
    checkOutput("tgt_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("gap%0d_valid", i), {31'b0, instr_valid}, 32'd0);
    end
    step();
    checkOutput("tgt_vvalid", {31'b0, instr_valid}, 32'd1);
    checkOutput("tgt_pc",     instr_pc,             32'h100);
    checkOutput("tgt_instr",  instr,                32'h100);

    // Field slicing, then redirect to the top word and wrap to zero.
    ackDelay = 0;
    useFixed = 1'b1;
    applyStimulus(1'b0);
    step();
    checkOutput("fld_instr", instr,         32'hE3A0_1005);
    checkOutput("fld_op",    {30'b0, op},   32'h0);
    checkOutput("fld_funct", {26'b0, funct}, 32'h3A);
    checkOutput("fld_rd",    {28'b0, rd},   32'h1);
    checkOutput("fld_pcp8",  pc_plus8,      32'h8);
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    checkOutput("wrap_addr",  imem_addr,            32'hFFFF_FFFC);
    checkOutput("wrap_valid", {31'b0, instr_valid}, 32'd0);
    step();
    checkOutput("wrap_next",  imem_addr, 32'h0);
    checkOutput("wrap_pc",    instr_pc,  32'hFFFF_FFFC);
    checkOutput("wrap_pcp8",  pc_plus8,  32'h4);
    useFixed = 1'b0;

    // Asynchronous reset while a request is pending and an instruction is queued.
    ackDelay = 1;
    applyStimulus(1'b0);
    step();
    step();
    checkOutput("ar_pre_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("ar_pre_req",   {31'b0, imem_req},    32'd1);
    checkOutput("ar_pre_addr",  imem_addr,            32'h4);
    rst_n = 1'b0;
    #1;
    checkOutput("ar_req",   {31'b0, imem_req},    32'd0);
    checkOutput("ar_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("ar_addr",  imem_addr,            32'h0);
    checkOutput("ar_instr", instr,                32'h0);
    checkOutput("ar_pcp8",  pc_plus8,             32'h8);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("ar_post_req",  {31'b0, imem_req}, 32'd1);
    checkOutput("ar_post_addr", imem_addr,         32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the instruction decoder. It generates fetch addresses and handles a req/ack handshake with instruction memory. Returned words are buffered in a 2-entry queue and presented to the decode/execute side with a valid/ready handshake. It also slices the Op, Funct and Rd fields the decoder consumes, and redirects the PC when the execute side reports a taken branch or a PC write.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `imem_req`, out, 1: fetch request; once asserted, held high until `imem_ack`.
- `imem_addr`, out, 32: word-aligned fetch address; stable while `imem_req` is high.
- `imem_ack`, in, 1: response valid this cycle; may coincide with the first cycle of `imem_req`.
- `imem_rdata`, in, 32: instruction word; valid when `imem_ack` is high.
- `instr_valid`, out, 1: queue head holds a valid instruction.
- `instr_ready`, in, 1: consumer accepts the head this cycle.
- `instr`, out, 32: instruction word at the queue head.
- `instr_pc`, out, 32: address of `instr`.
- `pc_plus8`, out, 32: `instr_pc` + 8, the architectural PC read value.
- `op`, out, 2: `instr[27:26]`.
- `funct`, out, 6: `instr[25:20]`.
- `rd`, out, 4: `instr[15:12]`.
- `redirect`, in, 1: taken branch or PC write (PCS gated by condition) for the instruction being consumed.
- `redirect_pc`, in, 32: target address; bits [1:0] are ignored.

## Operation
- A pop occurs when `instr_valid & instr_ready`. `take` = pop & `redirect`; `redirect` is ignored when there is no pop.
- Registers:
  - `fetch_pc`: address of the current or next request.
  - `target_q`: pending redirect target.
  - 2-entry queue of {word, pc}.
  - FSM state.
- FSM states and transitions:
  - IDLE: `imem_req`=0. Goes to FETCH unconditionally on the next cycle.
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - ack, no take: push {rdata, fetch_pc}; `fetch_pc`+=4. Go to WAIT if the post-update count is 2, else stay in FETCH.
    - ack with take: discard rdata; flush queue; `fetch_pc`<=target; stay in FETCH.
    - take, no ack: flush queue; `target_q`<=target; go to FLUSH (request stays up, address unchanged).
  - WAIT (queue full): `imem_req`=0.
    - pop without take: go to FETCH.
    - take: flush queue; `fetch_pc`<=target; go to FETCH.
  - FLUSH: `imem_req`=1 at the old `fetch_pc`. On ack: discard data; `fetch_pc`<=`target_q`; go to FETCH. `redirect` cannot occur here because the queue is empty.
- Simultaneous push and pop in the same cycle: count unchanged; FIFO order preserved.
- Flush clears both queue entries' valid bits; entry contents are don't-care except the head, which reads zero when empty.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert, sync release) sets:
  - state IDLE, `fetch_pc`=`RESET_PC`, queue empty.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instr_valid`=0; `instr`, `instr_pc`, `op`, `funct`, `rd` = 0; `pc_plus8`=8.
- Reset mid-request abandons the outstanding request. Memory must drop it on reset.
- First request: cycle 1 after release. With a zero-wait memory, `instr_valid` first rises at cycle 2.
- Fetch latency: ack-to-`instr_valid` is 1 cycle (registered queue). Queue outputs are registered, with no combinational path from `imem_rdata`.
- Throughput: 1 instruction/cycle with a zero-wait memory and `instr_ready` held high.
- Redirect penalty: the target request is issued the cycle after `take`, or the cycle after the flushing ack when in FLUSH.

## Structure
- Shared package `fetch_pkg`:
  - FSM state enum: IDLE, FETCH, WAIT, FLUSH.
  - `QDEPTH`=2.
  - Field bit-position constants for op/funct/rd.
- Sub-module `fetch_queue`: 2-entry FIFO of {word, pc} with push, pop, flush and count. The top level holds the FSM, the PC registers and the field slicing.

## Test plan
- Reset release; zero-wait memory returning data = addr; `instr_ready`=1 → `imem_addr` 0, 4, 8 on consecutive cycles; `instr_pc` 0, 4, 8 from cycle 2; `pc_plus8`=8 when `instr_pc`=0.
- `instr_ready`=0 from reset → entries 0 and 4 queued; `imem_req` drops (WAIT); `instr`=0 held. Raise ready → fetch resumes at 8 the next cycle.
- Consume pc 4 with `redirect`=1, `redirect_pc`=0x100 while the ack for 8 arrives → data for 8 dropped; next `imem_addr`=0x100; next `instr_pc`=0x100.
- Ack delayed 3 cycles; redirect to 0x100 while 8 is outstanding → `imem_addr` holds 8 until ack; data dropped; then request 0x100; no valid instruction in between.
- `imem_rdata`=0xE3A0_1005 → `op`=00, `funct`=111010, `rd`=0001.
- Assert `rst_n`=0 mid-FETCH with ack pending → `imem_req` and `instr_valid` clear immediately; after release the first request is at `RESET_PC`.
